prs_reset_sequencer: RTL and testbench

//   Sequences the active-low _Reset of a PRS co-simulated circuit (e.g. the ring

---
 rtl/prs_reset_sequencer_if.sv | 25 ++
 rtl/prs_reset_sequencer.sv | 146 ++++++++++++++
 tb/tb_prs_reset_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prs_reset_sequencer_if.sv
// Control/status bundle between a prsim VPI bench and the PRS reset sequencer.
// The bench drives start/abort/osc; the sequencer reports reset drive and liveness.
interface prs_reset_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             osc;
  logic             prs_reset_n;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] edge_count;
  logic [CNT_W-1:0] gap_max;

  modport master (
    output start, abort, osc,
    input  prs_reset_n, busy, pass, fail, edge_count, gap_max
  );

  modport slave (
    input  start, abort, osc,
    output prs_reset_n, busy, pass, fail, edge_count, gap_max
  );
endinterface

// File: rtl/prs_reset_sequencer.sv
// Holds a PRS circuit in reset, releases it, lets it settle, then checks that its
// output keeps toggling: TARGET_EDGES edges -> pass, inter-edge gap timeout -> fail.
module prs_reset_sequencer #(
  parameter int unsigned ASSERT_CYCLES  = 8,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TARGET_EDGES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input logic                  clk,
  input logic                  reset,
  prs_reset_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_SETTLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic [CNT_W-1:0] gap_max_q, gap_max_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             prs_reset_n_q, prs_reset_n_d;
  logic             busy_q, busy_d;
  logic             sync1_q, sync2_q, hist_q;

  logic             edge_c;
  logic [CNT_W-1:0] gap_c;

  // osc is asynchronous: two-flop synchroniser, then a history flop for edge detect
  assign edge_c = sync2_q ^ hist_q;
  assign gap_c  = gap_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ph_q          <= '0;
      gap_q         <= '0;
      edge_count_q  <= '0;
      gap_max_q     <= '0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      prs_reset_n_q <= 1'b0;
      busy_q        <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      hist_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      gap_q         <= gap_d;
      edge_count_q  <= edge_count_d;
      gap_max_q     <= gap_max_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      prs_reset_n_q <= prs_reset_n_d;
      busy_q        <= busy_d;
      sync1_q       <= bus.osc;
      sync2_q       <= sync1_q;
      hist_q        <= sync2_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    gap_d        = gap_q;
    edge_count_d = edge_count_q;
    gap_max_d    = gap_max_q;
    pass_d       = pass_q;
    fail_d       = fail_q;

    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_PASS, S_FAIL: begin
          if (bus.start) begin
            state_d      = S_ASSERT;
            ph_d         = '0;
            gap_d        = '0;
            edge_count_d = '0;
            gap_max_d    = '0;
            pass_d       = 1'b0;
            fail_d       = 1'b0;
          end
        end
        S_ASSERT: begin
          if (ph_q == CNT_W'(ASSERT_CYCLES - 1)) begin
            state_d = S_SETTLE;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (ph_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_d = S_RUN;
            ph_d    = '0;
            gap_d   = '0;
          end else begin
            ph_d = ph_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          // an edge on the timeout cycle still counts and restarts the gap
          if (edge_c) begin
            edge_count_d = edge_count_q + CNT_W'(1);
            gap_d        = '0;
            if (gap_c > gap_max_q) gap_max_d = gap_c;
            if (edge_count_d == CNT_W'(TARGET_EDGES)) begin
              state_d = S_PASS;
              pass_d  = 1'b1;
            end
          end else if (gap_c >= CNT_W'(TIMEOUT_CYCLES)) begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
            gap_d   = CNT_W'(TIMEOUT_CYCLES);
          end else begin
            gap_d = gap_c;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    prs_reset_n_d = state_d inside {S_SETTLE, S_RUN, S_PASS, S_FAIL};
    busy_d        = state_d inside {S_ASSERT, S_SETTLE, S_RUN};
  end

  assign bus.prs_reset_n = prs_reset_n_q;
  assign bus.busy        = busy_q;
  assign bus.pass        = pass_q;
  assign bus.fail        = fail_q;
  assign bus.edge_count  = edge_count_q;
  assign bus.gap_max     = gap_max_q;

endmodule

// File: tb/tb_prs_reset_sequencer.sv
// Self-checking bench for prs_reset_sequencer: directed scenarios plus randomized
// runs, compared every cycle against a timeline-based reference model.
module tb_prs_reset_sequencer;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned ASSERT_N  = 8;
  localparam int unsigned SETTLE_N  = 4;
  localparam int unsigned TARGET_N  = 16;
  localparam int unsigned TIMEOUT_N = 64;

  logic clk = 1'b0;
  logic reset;

  prs_reset_sequencer_if #(.CNT_W(CNT_W)) bus ();

  prs_reset_sequencer #(
    .ASSERT_CYCLES (ASSERT_N),
    .SETTLE_CYCLES (SETTLE_N),
    .TARGET_EDGES  (TARGET_N),
    .TIMEOUT_CYCLES(TIMEOUT_N),
    .CNT_W         (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned osc_period = 0;
  int unsigned osc_ph     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a sequence is a timeline counted in clk edges from the
  // accepted start; osc edges reach the sequencer from samples 2 and 3 edges old.
  int unsigned n, t0, last, m_cnt, m_gmax, m_mode;
  bit          m_pass, m_fail, d1, d2, d3;

  task automatic model_step();
    bit e;
    if (reset) begin
      n = 0; t0 = 0; last = 0; m_cnt = 0; m_gmax = 0; m_mode = 0;
      m_pass = 0; m_fail = 0; d1 = 0; d2 = 0; d3 = 0;
      return;
    end
    n++;
    e  = d2 ^ d3;
    d3 = d2; d2 = d1; d1 = bus.osc;
    if (bus.abort) begin
      m_mode = 0;
    end else if (m_mode != 1) begin
      if (bus.start) begin
        m_mode = 1; t0 = n; m_cnt = 0; m_gmax = 0; m_pass = 0; m_fail = 0;
        last = n + ASSERT_N + SETTLE_N;
      end
    end else if (n - t0 > ASSERT_N + SETTLE_N) begin
      if (e) begin
        m_cnt++;
        if (n - last > m_gmax) m_gmax = n - last;
        last = n;
        if (m_cnt == TARGET_N) begin m_mode = 2; m_pass = 1; end
      end else if (n - last >= TIMEOUT_N) begin
        m_mode = 2; m_fail = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // One clk cycle: compare against the model at the falling edge, then move osc.
  task automatic tick();
    @(negedge clk);
    cyc++;
    check_eq("busy", bus.busy, m_mode == 1);
    check_eq("prs_reset_n", bus.prs_reset_n, (m_mode == 1 && (n - t0) >= ASSERT_N) || m_mode == 2);
    check_eq("pass", bus.pass, m_pass);
    check_eq("fail", bus.fail, m_fail);
    check_eq("edge_count", bus.edge_count, m_cnt);
    check_eq("gap_max", bus.gap_max, m_gmax);
    if (osc_period != 0) begin
      if (osc_ph + 1 >= osc_period) begin
        bus.osc = ~bus.osc;
        osc_ph  = 0;
      end else begin
        osc_ph++;
      end
    end
  endtask

  task automatic set_osc(input int unsigned p);
    osc_period = p;
    osc_ph     = 0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      if (bus.pass || bus.fail) done = 1;
      else tick();
    end
    check_eq(tag, done, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lows, rise_cyc, fail_cyc;
    bit          done;

    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.osc = 1'b0;
    repeat (3) tick();
    check_eq("rst_prs_reset_n", bus.prs_reset_n, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_edge_count", bus.edge_count, 0);
    reset = 1'b0;
    tick();

    // 1: osc every 3 clk -> pass, reset low for exactly ASSERT cycles, gap_max 3
    set_osc(3);
    pulse_start();
    lows = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (bus.busy && !bus.prs_reset_n) lows++;
      if (bus.pass || bus.fail) done = 1; else tick();
    end
    check_eq("t1_done", done, 1);
    check_eq("t1_low_cycles", lows, ASSERT_N);
    check_eq("t1_pass", bus.pass, 1);
    check_eq("t1_fail", bus.fail, 0);
    check_eq("t1_gap_max", bus.gap_max, 3);
    check_eq("t1_edge_count", bus.edge_count, TARGET_N);
    check_eq("t1_prs_high", bus.prs_reset_n, 1);

    // 2: osc constant -> fail TIMEOUT cycles after RUN entry
    set_osc(0);
    repeat (5) tick();
    pulse_start();
    rise_cyc = 0; fail_cyc = 0;
    for (int i = 0; i < 300 && fail_cyc == 0; i++) begin
      if (rise_cyc == 0 && bus.prs_reset_n) rise_cyc = cyc;
      if (bus.fail) fail_cyc = cyc; else tick();
    end
    check_eq("t2_fail", bus.fail, 1);
    check_eq("t2_fail_delay", fail_cyc - rise_cyc, SETTLE_N + TIMEOUT_N);
    check_eq("t2_edge_count", bus.edge_count, 0);
    check_eq("t2_prs_high", bus.prs_reset_n, 1);
    repeat (3) tick();
    check_eq("t2_prs_stays", bus.prs_reset_n, 1);

    // 3: toggles only during ASSERT/SETTLE are not counted
    set_osc(1);
    pulse_start();
    repeat (6) tick();
    set_osc(0);
    wait_done("t3_done", 200);
    check_eq("t3_fail", bus.fail, 1);
    check_eq("t3_edge_count", bus.edge_count, 0);

    // 4: edge landing exactly on the timeout cycle is counted
    repeat (5) tick();
    pulse_start();
    repeat (ASSERT_N + SETTLE_N + TIMEOUT_N - 3) tick();
    bus.osc = ~bus.osc;
    repeat (4) tick();
    check_eq("t4_no_fail", bus.fail, 0);
    check_eq("t4_busy", bus.busy, 1);
    check_eq("t4_edge_count", bus.edge_count, 1);
    check_eq("t4_gap_max", bus.gap_max, TIMEOUT_N);
    wait_done("t4_done", 200);
    check_eq("t4_fail", bus.fail, 1);

    // 5: abort mid-RUN keeps results, restart clears and passes
    set_osc(3);
    pulse_start();
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus.edge_count == 5) done = 1; else tick();
    end
    check_eq("t5_reach5", done, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("t5_abort_busy", bus.busy, 0);
    check_eq("t5_abort_prs", bus.prs_reset_n, 0);
    check_eq("t5_abort_count", bus.edge_count, 5);
    pulse_start();
    check_eq("t5_cleared", bus.edge_count, 0);
    wait_done("t5_done", 400);
    check_eq("t5_pass", bus.pass, 1);
    check_eq("t5_count", bus.edge_count, TARGET_N);

    // 6: start while busy ignored; async reset mid-RUN
    set_osc(4);
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      bus.start = (i % 5 == 0);
      tick();
    end
    bus.start = 1'b0;
    check_eq("t6_still_busy", bus.busy, 1);
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.edge_count >= 3) done = 1; else tick();
    end
    check_eq("t6_reach3", done, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_rst_busy", bus.busy, 0);
    check_eq("t6_rst_prs", bus.prs_reset_n, 0);
    check_eq("t6_rst_count", bus.edge_count, 0);
    check_eq("t6_rst_gap_max", bus.gap_max, 0);
    check_eq("t6_rst_pass", bus.pass, 0);
    check_eq("t6_rst_fail", bus.fail, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (100) tick();
    check_eq("t6_idle_pass", bus.pass, 0);
    check_eq("t6_idle_fail", bus.fail, 0);
    check_eq("t6_idle_busy", bus.busy, 0);

    // Randomized runs around typical and boundary oscillation periods
    for (int it = 0; it < 25; it++) begin
      int unsigned r;
      r = $urandom_range(0, 11);
      case (r)
        0:       set_osc(0);
        1:       set_osc(63);
        2:       set_osc(64);
        3:       set_osc(65);
        4:       set_osc(70);
        default: set_osc($urandom_range(1, 12));
      endcase
      pulse_start();
      for (int i = 0; i < 1200 && bus.busy; i++) begin
        bus.start = ($urandom_range(0, 15) == 0);
        bus.abort = ($urandom_range(0, 199) == 0);
        tick();
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (2) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
